// File: rtl/iterative_divider_if.sv
// Request/result bus between the execute-stage issue logic and the iterative divider.
// The master issues operations and may cancel them; the slave is the divider.
interface iterative_divider_if #(
  parameter int WIDTH            = 32,
  parameter int ALUCONTROL_WIDTH = 6
);
  logic                        start;
  logic [ALUCONTROL_WIDTH-1:0] alu_control;
  logic [WIDTH-1:0]            dividend;
  logic [WIDTH-1:0]            divisor;
  logic                        cancel;
  logic                        busy;
  logic                        done;
  logic [WIDTH-1:0]            quotient;
  logic [WIDTH-1:0]            remainder;
  logic                        div_by_zero;

  modport master (
    output start, alu_control, dividend, divisor, cancel,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, alu_control, dividend, divisor, cancel,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for UDIV/SDIV: one quotient bit per cycle, sign fix-up at the end.
// Results stay held until the next completed operation; cancel aborts without touching them.
module iterative_divider #(
  parameter int WIDTH            = 32,
  parameter int ALUCONTROL_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  iterative_divider_if.slave   bus
);

  localparam logic [ALUCONTROL_WIDTH-1:0] OP_UDIV = ALUCONTROL_WIDTH'(6'b101110);
  localparam logic [ALUCONTROL_WIDTH-1:0] OP_SDIV = ALUCONTROL_WIDTH'(6'b101111);
  localparam int                          CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]            CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  state_e           state_q, state_d;

  logic             signed_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             dbz_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_res_q;
  logic [WIDTH-1:0] rem_res_q;
  logic [CNT_W-1:0] cnt_q;

  logic             op_ok;
  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             commit;

  assign op_ok  = (bus.alu_control == OP_UDIV) || (bus.alu_control == OP_SDIV);
  assign accept = bus.start && op_ok && !bus.cancel &&
                  ((state_q == S_IDLE) || (state_q == S_DONE));

  assign a_neg = signed_q & opa_q[WIDTH-1];
  assign b_neg = signed_q & opb_q[WIDTH-1];
  assign a_mag = a_neg ? (~opa_q + 1'b1) : opa_q;
  assign b_mag = b_neg ? (~opb_q + 1'b1) : opb_q;

  // The partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value
  // and bit WIDTH of the difference is the borrow.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};
  assign commit  = ~trial[WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: every clocked register uses <= so all flops sample the same pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so that no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    if (bus.cancel) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (accept) state_d = S_PREP;
        S_PREP:  state_d = (opb_q == '0) ? S_DONE : S_ITER;
        S_ITER:  if (cnt_q == CNT_LAST) state_d = S_FIX;
        S_FIX:   state_d = S_DONE;
        S_DONE:  state_d = accept ? S_PREP : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      signed_q  <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dbz_q     <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_res_q <= '0;
      rem_res_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        opa_q    <= bus.dividend;
        opb_q    <= bus.divisor;
        signed_q <= (bus.alu_control == OP_SDIV);
      end
      // A cancelled operation must leave the held results exactly as they were.
      if (!bus.cancel) begin
        unique case (state_q)
          S_PREP: begin
            dvd_q   <= a_mag;
            dvs_q   <= b_mag;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            if (opb_q == '0) begin
              quo_res_q <= '0;
              rem_res_q <= opa_q;
              dbz_q     <= 1'b1;
            end
          end
          S_ITER: begin
            rem_q <= commit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], commit};
            cnt_q <= cnt_q + CNT_W'(1);
          end
          S_FIX: begin
            quo_res_q <= q_neg_q ? (~dvd_q + 1'b1) : dvd_q;
            rem_res_q <= r_neg_q ? (~rem_q + 1'b1) : rem_q;
            dbz_q     <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy        = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
  assign bus.done        = (state_q == S_DONE);
  assign bus.quotient    = quo_res_q;
  assign bus.remainder   = rem_res_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed and random checks of iterative_divider against a plain-arithmetic reference model.
module tb_iterative_divider;

  localparam int          W    = 32;
  localparam logic [5:0]  UDIV = 6'b101110;
  localparam logic [5:0]  SDIV = 6'b101111;
  localparam logic [5:0]  ADD  = 6'b100000;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] prev_q  = '0;
  logic [31:0] prev_r  = '0;
  logic        prev_dz = 1'b0;

  iterative_divider_if #(.WIDTH(W), .ALUCONTROL_WIDTH(6)) bus ();

  iterative_divider #(.WIDTH(W), .ALUCONTROL_WIDTH(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer division as the language defines it, widened to avoid signed overflow.
  function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa;
    longint sb;
    if (b == 0) begin
      q = '0; r = a; dz = 1'b1;
    end else if (op == SDIV) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  // Issue at the current negedge; k counts edges after the accepting edge E0.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int cancel_at, input int inj_at);
    logic [31:0] eq, er;
    logic        ed;
    int          lat;
    bit          fin;
    model(op, a, b, eq, er, ed);
    lat = (b == 0) ? 1 : W + 2;
    bus.alu_control = op;
    bus.dividend    = a;
    bus.divisor     = b;
    bus.cancel      = 1'b0;
    bus.start       = 1'b1;
    fin = 1'b0;
    for (int k = 0; k <= W + 10 && !fin; k++) begin
      @(negedge clk);
      bus.start  = (k == inj_at);
      bus.cancel = (k == cancel_at);
      if (k == inj_at) begin
        bus.alu_control = UDIV; bus.dividend = 32'd1; bus.divisor = 32'd1;
      end else begin
        bus.dividend = $urandom; bus.divisor = $urandom;
      end
      if (cancel_at >= 0 && k == cancel_at + 1) begin
        chk("cancel_busy_done", 32'({bus.busy, bus.done}), 32'd0);
        chk("cancel_q_held", bus.quotient, prev_q);
        chk("cancel_r_held", bus.remainder, prev_r);
        chk("cancel_dz_held", 32'(bus.div_by_zero), 32'(prev_dz));
        fin = 1'b1;
      end else if (k < lat) begin
        chk("busy_phase", 32'({bus.busy, bus.done}), 32'b10);
      end else if (k == lat) begin
        chk("done_phase", 32'({bus.busy, bus.done}), 32'b01);
        chk("quotient", bus.quotient, eq);
        chk("remainder", bus.remainder, er);
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(ed));
        prev_q = eq; prev_r = er; prev_dz = ed;
        fin = 1'b1;
      end
    end
    chk("op_finished", 32'(fin), 32'd1);
  endtask

  initial begin
    int pulses;
    int busy_seen;
    logic [5:0]  rop;
    logic [31:0] ra, rb;

    bus.start = 1'b0; bus.cancel = 1'b0; bus.alu_control = '0;
    bus.dividend = '0; bus.divisor = '0;

    #12;
    chk("reset_busy_done", 32'({bus.busy, bus.done}), 32'd0);
    chk("reset_q", bus.quotient, 32'd0);
    chk("reset_r", bus.remainder, 32'd0);
    chk("reset_dz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(UDIV, 32'd100, 32'd7, -1, -1);
    chk("udiv_100_7_q", bus.quotient, 32'd14);
    chk("udiv_100_7_r", bus.remainder, 32'd2);
    run_op(SDIV, -32'sd100, 32'd7, -1, -1);
    chk("sdiv_m100_7_q", bus.quotient, 32'hFFFF_FFF2);
    chk("sdiv_m100_7_r", bus.remainder, 32'hFFFF_FFFE);
    run_op(SDIV, 32'd100, -32'sd7, -1, -1);
    chk("sdiv_100_m7_q", bus.quotient, 32'hFFFF_FFF2);
    chk("sdiv_100_m7_r", bus.remainder, 32'd2);
    run_op(SDIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    chk("sdiv_ovf_q", bus.quotient, 32'h8000_0000);
    chk("sdiv_ovf_r", bus.remainder, 32'd0);
    run_op(UDIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    chk("udiv_ext_q", bus.quotient, 32'd0);
    chk("udiv_ext_r", bus.remainder, 32'h8000_0000);
    run_op(UDIV, 32'd55, 32'd0, -1, -1);
    chk("dbz_r", bus.remainder, 32'd55);
    chk("dbz_flag", 32'(bus.div_by_zero), 32'd1);

    // Cancel in ITER cycle 10, then make sure no late done appears.
    run_op(UDIV, 32'd1000, 32'd3, 10, -1);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("no_done_after_cancel", 32'(pulses), 32'd0);
    chk("held_after_cancel_r", bus.remainder, 32'd55);

    // Unsupported opcode and start-with-cancel are both ignored.
    bus.alu_control = ADD; bus.dividend = 32'd10; bus.divisor = 32'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    busy_seen = 0;
    repeat (4) begin
      if (bus.busy) busy_seen++;
      @(negedge clk);
    end
    chk("add_ignored", 32'(busy_seen), 32'd0);
    bus.alu_control = UDIV; bus.start = 1'b1; bus.cancel = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    busy_seen = 0;
    repeat (4) begin
      if (bus.busy) busy_seen++;
      @(negedge clk);
    end
    chk("start_cancel_ignored", 32'(busy_seen), 32'd0);

    // A start pulse while busy must not disturb the running operation.
    run_op(UDIV, 32'd100, 32'd7, -1, 5);
    chk("inj_ignored_q", bus.quotient, 32'd14);

    // Random back-to-back operations.
    for (int i = 0; i < 12; i++) begin
      rop = ($urandom_range(0, 1) == 1) ? SDIV : UDIV;
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(1, 15));
        1:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if (i == 5) rb = '0;
      run_op(rop, ra, rb, -1, -1);
    end

    // Asynchronous reset in ITER cycle 5.
    bus.alu_control = UDIV; bus.dividend = 32'd77; bus.divisor = 32'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy_done", 32'({bus.busy, bus.done}), 32'd0);
    chk("async_rst_q", bus.quotient, 32'd0);
    chk("async_rst_r", bus.remainder, 32'd0);
    chk("async_rst_dz", 32'(bus.div_by_zero), 32'd0);
    prev_q = '0; prev_r = '0; prev_dz = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_op(UDIV, 32'd9, 32'd3, -1, -1);
    chk("post_rst_q", bus.quotient, 32'd3);
    chk("post_rst_r", bus.remainder, 32'd0);

    @(negedge clk);
    bus.start = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
